sargantana_icache_refill_buffer: RTL and testbench

Refill-side stage that feeds the per-way icache data SRAMs. Collects a missing line from the memory response channel as BEAT_WIDTH-wide beats and assembles a full SET_WIDHT line in a local buffer. Then issues a single-cycle write (req/we/addr/data) to the selected way's SRAM once the SRAM port is granted. Sits between the miss/refill controller plus memory response path upstream and the way SRAM array downstream.

---
 rtl/sargantana_icache_refill_buffer.sv | 149 ++++++++++++++
 tb/tb_sargantana_icache_refill_buffer.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sargantana_icache_refill_buffer.sv
// -----------------------------------------------------------------------------
// sargantana_icache_refill_buffer
//
// Refill-side stage in front of the per-way icache data SRAMs. A refill starts
// with the target set and victim way. The missing line then arrives as
// BEAT_WIDTH-wide response beats, and beat 0 lands in the LSBs of the local
// line buffer. When the line is complete, a single write is presented to the
// selected way SRAM and held until the lookup arbiter grants the port. A
// one-cycle done pulse follows the write.
//
// Ports:
//   clk_i, rstn_i              clock, asynchronous active-low reset
//   start_valid_i/ready_o      refill request (accepted only in IDLE)
//   start_set_i, start_way_i   set index and binary victim way of the refill
//   beat_valid_i/ready_o       response beat handshake (accepted only in FILL)
//   beat_data_i                response beat payload
//   abort_i                    kill an in-flight refill (flush / fence.i)
//   wr_gnt_i                   SRAM port grant from the lookup arbiter
//   way_req_o                  one-hot SRAM enable, one bit per way
//   way_we_o, way_addr_o       SRAM write enable and set address
//   way_data_o                 assembled line
//   busy_o                     refill in progress (not IDLE)
//   done_o                     one-cycle pulse after the line is written
// -----------------------------------------------------------------------------
module sargantana_icache_refill_buffer #(
  parameter int SET_WIDHT  = 256,
  parameter int ADDR_WIDHT = 6,
  parameter int BEAT_WIDTH = 64,
  parameter int WAYS       = 4
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    start_valid_i,
  output logic                    start_ready_o,
  input  logic [ADDR_WIDHT-1:0]   start_set_i,
  input  logic [$clog2(WAYS)-1:0] start_way_i,
  input  logic                    beat_valid_i,
  input  logic [BEAT_WIDTH-1:0]   beat_data_i,
  output logic                    beat_ready_o,
  input  logic                    abort_i,
  input  logic                    wr_gnt_i,
  output logic [WAYS-1:0]         way_req_o,
  output logic                    way_we_o,
  output logic [ADDR_WIDHT-1:0]   way_addr_o,
  output logic [SET_WIDHT-1:0]    way_data_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int BEATS = SET_WIDHT / BEAT_WIDTH;
  localparam int CNT_W = $clog2(BEATS);
  localparam int WAY_W = $clog2(WAYS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [SET_WIDHT-1:0]    r_line;
  logic [ADDR_WIDHT-1:0]   r_set;
  logic [WAY_W-1:0]        r_way;
  logic [WAYS-1:0]         w_way_onehot;
  logic                    w_last_beat;

  assign w_last_beat = beat_valid_i && (r_cnt == LAST_BEAT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // NOTE: every signal driven here gets a default first; a path that left one
  // unassigned would infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start_valid_i) w_next_state = S_FILL;
      S_FILL: begin
        if (abort_i)          w_next_state = S_IDLE;
        else if (w_last_beat) w_next_state = S_WRITE;
      end
      // The grant wins over a simultaneous abort: the write has already
      // been committed to the SRAM in that cycle.
      S_WRITE: begin
        if (wr_gnt_i)     w_next_state = S_DONE;
        else if (abort_i) w_next_state = S_IDLE;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: the line buffer is a plain flop register (not an SRAM macro), so it
  // can be cleared by reset like the rest of the datapath.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cnt  <= '0;
      r_line <= '0;
      r_set  <= '0;
      r_way  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_valid_i) begin
            r_set <= start_set_i;
            r_way <= start_way_i;
            r_cnt <= '0;
          end
        end
        S_FILL: begin
          if (abort_i) begin
            r_cnt <= '0;
          end else if (beat_valid_i) begin
            for (int b = 0; b < BEATS; b++) begin
              if (r_cnt == CNT_W'(b)) r_line[b*BEAT_WIDTH +: BEAT_WIDTH] <= beat_data_i;
            end
            r_cnt <= w_last_beat ? '0 : r_cnt + 1'b1;
          end
        end
        S_WRITE: begin
          if (abort_i && !wr_gnt_i) r_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign w_way_onehot = {{(WAYS-1){1'b0}}, 1'b1} << r_way;

  // Outputs decode straight from the state register, so an asserted reset
  // drops way_req_o without waiting for a clock edge.
  assign start_ready_o = (r_state == S_IDLE);
  assign beat_ready_o  = (r_state == S_FILL);
  assign way_req_o     = (r_state == S_WRITE) ? w_way_onehot : '0;
  assign way_we_o      = (r_state == S_WRITE);
  assign way_addr_o    = (r_state == S_WRITE) ? r_set : '0;
  assign way_data_o    = r_line;
  assign busy_o        = (r_state != S_IDLE);
  assign done_o        = (r_state == S_DONE);

endmodule

// File: tb/tb_sargantana_icache_refill_buffer.sv
// -----------------------------------------------------------------------------
// tb_sargantana_icache_refill_buffer
//
// Self-checking bench. Each refill is described by its set, way and the full
// line. The bench slices the line into beats to drive the response channel.
// The expected SRAM write is simply that line, the set, and a one-hot way
// built with a shift. The expected done time is the sum of the cycles spent in
// each phase. A negedge monitor counts SRAM request cycles, committed writes
// and done pulses, and records the last committed write.
// -----------------------------------------------------------------------------
module tb_sargantana_icache_refill_buffer;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 6;
  localparam int BEAT_W = 64;
  localparam int WAYS   = 4;
  localparam int WAY_W  = $clog2(WAYS);
  localparam int BEATS  = LINE_W / BEAT_W;

  logic              clk_i = 1'b0;
  logic              rstn_i = 1'b0;
  logic              start_valid_i = 1'b0;
  logic              start_ready_o;
  logic [ADDR_W-1:0] start_set_i = '0;
  logic [WAY_W-1:0]  start_way_i = '0;
  logic              beat_valid_i = 1'b0;
  logic [BEAT_W-1:0] beat_data_i = '0;
  logic              beat_ready_o;
  logic              abort_i = 1'b0;
  logic              wr_gnt_i = 1'b0;
  logic [WAYS-1:0]   way_req_o;
  logic              way_we_o;
  logic [ADDR_W-1:0] way_addr_o;
  logic [LINE_W-1:0] way_data_o;
  logic              busy_o;
  logic              done_o;

  int errors = 0;
  int checks = 0;

  int                n_req_cycles = 0;
  int                n_writes = 0;
  int                n_done = 0;
  logic [WAYS-1:0]   last_req = '0;
  logic              last_we = 1'b0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [LINE_W-1:0] last_data = '0;

  sargantana_icache_refill_buffer #(
    .SET_WIDHT (LINE_W),
    .ADDR_WIDHT(ADDR_W),
    .BEAT_WIDTH(BEAT_W),
    .WAYS      (WAYS)
  ) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .start_valid_i(start_valid_i),
    .start_ready_o(start_ready_o),
    .start_set_i  (start_set_i),
    .start_way_i  (start_way_i),
    .beat_valid_i (beat_valid_i),
    .beat_data_i  (beat_data_i),
    .beat_ready_o (beat_ready_o),
    .abort_i      (abort_i),
    .wr_gnt_i     (wr_gnt_i),
    .way_req_o    (way_req_o),
    .way_we_o     (way_we_o),
    .way_addr_o   (way_addr_o),
    .way_data_o   (way_data_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (rstn_i) begin
      if (way_req_o != '0) begin
        n_req_cycles++;
        if (wr_gnt_i) begin
          n_writes++;
          last_req  = way_req_o;
          last_we   = way_we_o;
          last_addr = way_addr_o;
          last_data = way_data_o;
        end
      end
      if (done_o) n_done++;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [WAYS-1:0] onehot(input logic [WAY_W-1:0] way);
    logic [WAYS-1:0] one;
    one = 1;
    return one << way;
  endfunction

  // Presents a start request for one edge; the request is accepted on it.
  task automatic start_req(input logic [ADDR_W-1:0] set, input logic [WAY_W-1:0] way);
    start_valid_i = 1'b1;
    start_set_i   = set;
    start_way_i   = way;
    tick();
    start_valid_i = 1'b0;
  endtask

  // Sends the beats of a line LSB-first with random idle gaps; returns the
  // number of edges used.
  task automatic send_line(input logic [LINE_W-1:0] line, input int gap_min,
                           input int gap_max, output int edges);
    int gap;
    edges = 0;
    for (int b = 0; b < BEATS; b++) begin
      gap = $urandom_range(gap_max, gap_min);
      repeat (gap) begin tick(); edges++; end
      beat_valid_i = 1'b1;
      beat_data_i  = line[b*BEAT_W +: BEAT_W];
      tick();
      edges++;
      beat_valid_i = 1'b0;
      beat_data_i  = '0;
    end
  endtask

  // Full refill. wr_abort: 0 = plain grant, 1 = abort together with the
  // grant (write must still commit), 2 = abort instead of the grant.
  task automatic refill(input logic [ADDR_W-1:0] set, input logic [WAY_W-1:0] way,
                        input logic [LINE_W-1:0] line, input int gap_min, input int gap_max,
                        input int gnt_delay, input int wr_abort);
    int edges;
    int fill_edges;
    int w0, d0, r0;
    logic [WAYS-1:0] exp_req;
    exp_req = onehot(way);
    w0 = n_writes; d0 = n_done; r0 = n_req_cycles;
    start_req(set, way);
    send_line(line, gap_min, gap_max, fill_edges);
    edges = fill_edges;
    for (int d = 0; d < gnt_delay; d++) begin
      @(negedge clk_i);
      checks++;
      if (way_req_o !== exp_req || way_we_o !== 1'b1 || way_addr_o !== set || way_data_o !== line) begin
        errors++;
        $display("FAIL write_hold cyc%0d: req=%b we=%b addr=%h data=%h, want req=%b we=1 addr=%h data=%h",
                 d, way_req_o, way_we_o, way_addr_o, way_data_o, exp_req, set, line);
      end
      tick();
      edges++;
    end
    if (wr_abort == 2) begin
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (busy_o !== 1'b0 || start_ready_o !== 1'b1 || way_req_o !== '0 || done_o !== 1'b0) begin
        errors++;
        $display("FAIL abort_write: busy=%b start_ready=%b req=%b done=%b, want 0 1 0 0",
                 busy_o, start_ready_o, way_req_o, done_o);
      end
      @(negedge clk_i);
      checks++;
      if (n_writes !== w0 || n_done !== d0) begin
        errors++;
        $display("FAIL abort_write_side: writes=%0d done=%0d, want 0 0", n_writes - w0, n_done - d0);
      end
      return;
    end
    wr_gnt_i = 1'b1;
    abort_i  = (wr_abort == 1);
    tick();
    edges++;
    wr_gnt_i = 1'b0;
    abort_i  = 1'b0;
    @(negedge clk_i);
    checks++;
    if (done_o !== 1'b1 || way_req_o !== '0) begin
      errors++;
      $display("FAIL done_pulse: done=%b req=%b, want 1 0", done_o, way_req_o);
    end
    // Edges after the accepting edge until done_o shows: the beat edges
    // (including gaps), any grant wait, and the granted WRITE edge. With no
    // gaps or wait this is BEATS+1, i.e. done_o in the (BEATS+3)th cycle
    // counting the accept cycle as the first.
    checks++;
    if (edges !== fill_edges + gnt_delay + 1 || fill_edges < BEATS) begin
      errors++;
      $display("FAIL latency: edges=%0d, want %0d", edges, fill_edges + gnt_delay + 1);
    end
    checks++;
    if (n_writes !== w0 + 1 || last_req !== exp_req || last_we !== 1'b1 ||
        last_addr !== set || last_data !== line) begin
      errors++;
      $display("FAIL write: n=%0d req=%b we=%b addr=%h data=%h, want n=1 req=%b we=1 addr=%h data=%h",
               n_writes - w0, last_req, last_we, last_addr, last_data, exp_req, set, line);
    end
    tick();
    @(negedge clk_i);
    checks++;
    if (done_o !== 1'b0 || start_ready_o !== 1'b1 || busy_o !== 1'b0 ||
        n_done !== d0 + 1 || n_req_cycles !== r0 + gnt_delay + 1) begin
      errors++;
      $display("FAIL post_done: done=%b start_ready=%b busy=%b pulses=%0d req_cycles=%0d, want 0 1 0 1 %0d",
               done_o, start_ready_o, busy_o, n_done - d0, n_req_cycles - r0, gnt_delay + 1);
    end
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    checks++;
    if (start_ready_o !== 1'b1 || beat_ready_o !== 1'b0 || way_req_o !== '0 || way_we_o !== 1'b0 ||
        way_addr_o !== '0 || way_data_o !== '0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: sr=%b br=%b req=%b we=%b addr=%h data=%h busy=%b done=%b",
               start_ready_o, beat_ready_o, way_req_o, way_we_o, way_addr_o, way_data_o, busy_o, done_o);
    end
    rstn_i = 1'b1;
    tick();
    @(negedge clk_i);
    checks++;
    if (start_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: start_ready=%b busy=%b, want 1 0", start_ready_o, busy_o);
    end
  endtask

  task automatic test_basic();
    logic [LINE_W-1:0] line;
    line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    wr_gnt_i = 1'b1;  // grant held high through the whole refill
    refill(6'h2A, 2'd2, line, 0, 0, 0, 0);
  endtask

  task automatic test_gapped_delayed_grant();
    refill(6'h17, 2'd1, rand_line(), 2, 2, 5, 0);
  endtask

  task automatic test_abort_fill();
    int edges;
    int w0, d0, r0;
    logic [LINE_W-1:0] junk;
    junk = '1;
    w0 = n_writes; d0 = n_done; r0 = n_req_cycles;
    start_req(6'h13, 2'd3);
    for (int b = 0; b < 2; b++) begin
      beat_valid_i = 1'b1;
      beat_data_i  = junk[b*BEAT_W +: BEAT_W];
      tick();
    end
    beat_valid_i = 1'b0;
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0 || start_ready_o !== 1'b1 || beat_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_fill: busy=%b start_ready=%b beat_ready=%b, want 0 1 0",
               busy_o, start_ready_o, beat_ready_o);
    end
    // Leftover beats from the aborted line arrive while idle.
    beat_valid_i = 1'b1;
    beat_data_i  = junk[BEAT_W-1:0];
    tick();
    tick();
    beat_valid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (n_req_cycles !== r0 || n_writes !== w0 || n_done !== d0) begin
      errors++;
      $display("FAIL abort_fill_side: req_cycles=%0d writes=%0d done=%0d, want 0 0 0",
               n_req_cycles - r0, n_writes - w0, n_done - d0);
    end
    edges = 0;
    refill(6'h05, 2'd0, rand_line(), 0, 1, 0, 0);
  endtask

  task automatic test_abort_write();
    refill(6'h31, 2'd3, rand_line(), 0, 1, 2, 1);
    refill(6'h0C, 2'd1, rand_line(), 0, 1, 1, 2);
  endtask

  task automatic test_illegal_inputs();
    int edges;
    logic [LINE_W-1:0] line;
    logic [BEAT_W-1:0] junk;
    line = rand_line();
    junk = {$urandom, $urandom};
    // Beats while idle.
    beat_valid_i = 1'b1;
    beat_data_i  = junk;
    @(negedge clk_i);
    checks++;
    if (beat_ready_o !== 1'b0 || start_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL idle_beat: beat_ready=%b start_ready=%b, want 0 1", beat_ready_o, start_ready_o);
    end
    tick();
    tick();
    beat_valid_i = 1'b0;
    start_req(6'h22, 2'd2);
    beat_valid_i = 1'b1;
    beat_data_i  = line[BEAT_W-1:0];
    tick();
    beat_valid_i = 1'b0;
    // Second start during FILL with a different set/way.
    start_valid_i = 1'b1;
    start_set_i   = 6'h3F;
    start_way_i   = 2'd1;
    @(negedge clk_i);
    checks++;
    if (start_ready_o !== 1'b0 || beat_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL fill_start: start_ready=%b beat_ready=%b, want 0 1", start_ready_o, beat_ready_o);
    end
    tick();
    start_valid_i = 1'b0;
    for (int b = 1; b < BEATS; b++) begin
      beat_valid_i = 1'b1;
      beat_data_i  = line[b*BEAT_W +: BEAT_W];
      tick();
    end
    // Junk beats through WRITE (two waits, then grant) and DONE.
    beat_data_i = junk;
    @(negedge clk_i);
    checks++;
    if (beat_ready_o !== 1'b0 || way_req_o !== onehot(2'd2)) begin
      errors++;
      $display("FAIL write_beat: beat_ready=%b req=%b, want 0 %b", beat_ready_o, way_req_o, onehot(2'd2));
    end
    tick();
    tick();
    wr_gnt_i = 1'b1;
    tick();
    wr_gnt_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (beat_ready_o !== 1'b0 || start_ready_o !== 1'b0 || done_o !== 1'b1) begin
      errors++;
      $display("FAIL done_beat: beat_ready=%b start_ready=%b done=%b, want 0 0 1",
               beat_ready_o, start_ready_o, done_o);
    end
    checks++;
    if (last_req !== onehot(2'd2) || last_addr !== 6'h22 || last_data !== line) begin
      errors++;
      $display("FAIL illegal_write: req=%b addr=%h data=%h, want %b 22 %h",
               last_req, last_addr, last_data, onehot(2'd2), line);
    end
    tick();
    beat_valid_i = 1'b0;
    beat_data_i  = '0;
    edges = 0;
    // A clean follow-up refill exposes any counter disturbance.
    refill(6'h09, 2'd3, rand_line(), 0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      refill(ADDR_W'($urandom), WAY_W'($urandom), rand_line(), 0, 2,
             $urandom_range(3, 0), ($urandom_range(3, 0) == 0) ? 1 : 0);
    end
  endtask

  task automatic test_reset_mid_write();
    int edges;
    int w0;
    logic [LINE_W-1:0] line;
    line = rand_line();
    w0 = n_writes;
    start_req(6'h1B, 2'd1);
    send_line(line, 0, 1, edges);
    @(negedge clk_i);
    checks++;
    if (way_req_o !== onehot(2'd1)) begin
      errors++;
      $display("FAIL pre_reset_req: req=%b, want %b", way_req_o, onehot(2'd1));
    end
    #2;
    rstn_i = 1'b0;
    #1;
    checks++;
    if (way_req_o !== '0 || busy_o !== 1'b0 || start_ready_o !== 1'b1 || way_data_o !== '0) begin
      errors++;
      $display("FAIL async_reset: req=%b busy=%b start_ready=%b data=%h, want 0 0 1 0",
               way_req_o, busy_o, start_ready_o, way_data_o);
    end
    @(negedge clk_i);
    rstn_i = 1'b1;
    tick();
    checks++;
    if (n_writes !== w0) begin
      errors++;
      $display("FAIL reset_partial_write: writes=%0d, want 0", n_writes - w0);
    end
  endtask

  task automatic test_back_to_back();
    refill(6'h10, 2'd0, rand_line(), 0, 0, 0, 0);
    refill(6'h11, 2'd2, rand_line(), 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped_delayed_grant();
    test_abort_fill();
    test_abort_write();
    test_illegal_inputs();
    test_random();
    test_reset_mid_write();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog: a stuck DUT still reaches a report.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
